// File: rtl/rs_slot_array_if.sv
// -----------------------------------------------------------------------------
// rs_slot_array_if
// Dispatch handshake bundle between the rename/dispatch stage (master) and the
// reservation-station slot array (slave).
//   disp_valid      master -> slave : an entry is offered this cycle
//   disp_ready      slave  -> master: at least one slot is free
//   disp_tag/op     master -> slave : entry age tag and opcode
//   disp_srcN_*     master -> slave : per-operand ready flag, value, producer tag
// -----------------------------------------------------------------------------
interface rs_slot_array_if #(
    parameter int TAG_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
);
    logic                  disp_valid;
    logic                  disp_ready;
    logic [TAG_WIDTH-1:0]  disp_tag;
    logic [OP_WIDTH-1:0]   disp_op;
    logic                  disp_src1_rdy;
    logic [DATA_WIDTH-1:0] disp_src1_val;
    logic [TAG_WIDTH-1:0]  disp_src1_tag;
    logic                  disp_src2_rdy;
    logic [DATA_WIDTH-1:0] disp_src2_val;
    logic [TAG_WIDTH-1:0]  disp_src2_tag;

    modport master (
        output disp_valid, disp_tag, disp_op,
               disp_src1_rdy, disp_src1_val, disp_src1_tag,
               disp_src2_rdy, disp_src2_val, disp_src2_tag,
        input  disp_ready
    );

    modport slave (
        input  disp_valid, disp_tag, disp_op,
               disp_src1_rdy, disp_src1_val, disp_src1_tag,
               disp_src2_rdy, disp_src2_val, disp_src2_tag,
        output disp_ready
    );
endinterface

// File: rtl/rs_slot_array.sv
// -----------------------------------------------------------------------------
// rs_slot_array
// Reservation-station entry storage: allocates incoming dispatches into the
// lowest free slot, wakes operands from the result broadcast bus (CDB), exposes
// per-slot ready/age information to an external issue selector and frees the
// slot it grants.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   disp_if (slave)   dispatch handshake and entry payload
//   cdb_*_i           result broadcast (valid, producer tag, data)
//   iss_valid_i/slot  issue grant from the FU selector
//   flush_i           invalidate every entry
//   rv_ready_o        per-slot ready-to-issue
//   rv_out_tag_o      per-slot age tag, slot i at [i*TAG_WIDTH +: TAG_WIDTH]
//   iss_*_o           contents of slot iss_slot_i (combinational read)
//   occupancy_o       number of valid entries
//   err_issue_o       sticky bad-issue flag (only with RS_ISSUE_CHECK_EN)
//
// Optional feature macro: RS_ISSUE_CHECK_EN -- when defined, an issue grant to
// a slot that is not ready is ignored and raises err_issue_o.
// -----------------------------------------------------------------------------
module rs_slot_array #(
    parameter int NUM_SLOTS  = 8,
    parameter int TAG_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    rs_slot_array_if.slave                 disp_if,
    input  logic                           cdb_valid_i,
    input  logic [TAG_WIDTH-1:0]           cdb_tag_i,
    input  logic [DATA_WIDTH-1:0]          cdb_data_i,
    input  logic                           iss_valid_i,
    input  logic [$clog2(NUM_SLOTS)-1:0]   iss_slot_i,
    input  logic                           flush_i,
    output logic [NUM_SLOTS-1:0]           rv_ready_o,
    output logic [NUM_SLOTS*TAG_WIDTH-1:0] rv_out_tag_o,
    output logic [OP_WIDTH-1:0]            iss_op_o,
    output logic [DATA_WIDTH-1:0]          iss_src1_o,
    output logic [DATA_WIDTH-1:0]          iss_src2_o,
    output logic [TAG_WIDTH-1:0]           iss_tag_o,
    output logic [$clog2(NUM_SLOTS):0]     occupancy_o
`ifdef RS_ISSUE_CHECK_EN
    ,
    output logic                           err_issue_o
`endif
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int OCC_W  = SLOT_W + 1;

    // Index of the lowest clear bit; only meaningful when some bit is clear.
    function automatic logic [SLOT_W-1:0] find_free(input logic [NUM_SLOTS-1:0] v);
        logic [SLOT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!v[i]) begin
                idx = SLOT_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Slot state
    logic [NUM_SLOTS-1:0]  valid_q, valid_d;
    logic [NUM_SLOTS-1:0]  src1_rdy_q, src1_rdy_d;
    logic [NUM_SLOTS-1:0]  src2_rdy_q, src2_rdy_d;
    logic [OP_WIDTH-1:0]   op_q [NUM_SLOTS];
    logic [OP_WIDTH-1:0]   op_d [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  tag_q [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  tag_d [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  src1_tag_q [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  src1_tag_d [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  src2_tag_q [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  src2_tag_d [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] src1_val_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] src1_val_d [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] src2_val_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] src2_val_d [NUM_SLOTS];
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic                  disp_ready_s;
    logic                  disp_fire_s;
    logic                  iss_fire_s;
    logic                  cdb_hit_s;
    logic [SLOT_W-1:0]     alloc_slot_s;
    logic [NUM_SLOTS-1:0]  rv_ready_s;

    // Ready/allocation decisions look only at registered state, so a slot freed
    // by issue this cycle cannot be reallocated until the next cycle.
    assign rv_ready_s         = valid_q & src1_rdy_q & src2_rdy_q;
    assign rv_ready_o         = rv_ready_s;
    assign disp_ready_s       = ~(&valid_q);
    assign disp_if.disp_ready = disp_ready_s;
    assign disp_fire_s        = disp_if.disp_valid && disp_ready_s;
    assign alloc_slot_s       = find_free(valid_q);
    // Tag 0 never names a producer, so a broadcast with tag 0 wakes nothing.
    assign cdb_hit_s          = cdb_valid_i && (cdb_tag_i != {TAG_WIDTH{1'b0}});
    assign occupancy_o        = occ_q;

    assign iss_op_o   = op_q[iss_slot_i];
    assign iss_src1_o = src1_val_q[iss_slot_i];
    assign iss_src2_o = src2_val_q[iss_slot_i];
    assign iss_tag_o  = tag_q[iss_slot_i];

`ifdef RS_ISSUE_CHECK_EN
    logic err_issue_q, err_issue_d;
    logic iss_bad_s;

    assign iss_fire_s  = iss_valid_i && rv_ready_s[iss_slot_i];
    assign iss_bad_s   = iss_valid_i && !rv_ready_s[iss_slot_i];
    assign err_issue_o = err_issue_q;

    // Sticky bad-issue flag next state.
    always_comb begin
        err_issue_d = err_issue_q | iss_bad_s;
    end

    // Sticky bad-issue flag register; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_issue_q <= 1'b0;
        end else begin
            err_issue_q <= err_issue_d;
        end
    end
`else
    // Freeing an already-empty slot is a no-op, so gate on valid to keep the
    // occupancy count consistent with the valid bits.
    assign iss_fire_s = iss_valid_i && valid_q[iss_slot_i];
`endif

    // Per-slot age tags, including the stale tag of invalid slots.
    always_comb begin
        rv_out_tag_o = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            rv_out_tag_o[i*TAG_WIDTH +: TAG_WIDTH] = tag_q[i];
        end
    end

    // Next-state: flush overrides everything; otherwise wakeup, issue and
    // dispatch are applied together (they can never target the same slot).
    always_comb begin
        valid_d    = valid_q;
        src1_rdy_d = src1_rdy_q;
        src2_rdy_d = src2_rdy_q;
        op_d       = op_q;
        tag_d      = tag_q;
        src1_tag_d = src1_tag_q;
        src2_tag_d = src2_tag_q;
        src1_val_d = src1_val_q;
        src2_val_d = src2_val_q;
        occ_d      = occ_q;

        if (flush_i) begin
            valid_d = '0;
            occ_d   = '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid_q[i] && cdb_hit_s && !src1_rdy_q[i] && (src1_tag_q[i] == cdb_tag_i)) begin
                    src1_rdy_d[i] = 1'b1;
                    src1_val_d[i] = cdb_data_i;
                end else begin
                    src1_val_d[i] = src1_val_q[i];
                end
                if (valid_q[i] && cdb_hit_s && !src2_rdy_q[i] && (src2_tag_q[i] == cdb_tag_i)) begin
                    src2_rdy_d[i] = 1'b1;
                    src2_val_d[i] = cdb_data_i;
                end else begin
                    src2_val_d[i] = src2_val_q[i];
                end
            end

            if (iss_fire_s) begin
                valid_d[iss_slot_i] = 1'b0;
            end else begin
                valid_d[iss_slot_i] = valid_q[iss_slot_i];
            end

            if (disp_fire_s) begin
                valid_d[alloc_slot_s]    = 1'b1;
                op_d[alloc_slot_s]       = disp_if.disp_op;
                tag_d[alloc_slot_s]      = disp_if.disp_tag;
                src1_tag_d[alloc_slot_s] = disp_if.disp_src1_tag;
                src2_tag_d[alloc_slot_s] = disp_if.disp_src2_tag;
                // Same-cycle bypass: the producer is broadcasting right now.
                if (!disp_if.disp_src1_rdy && cdb_hit_s && (disp_if.disp_src1_tag == cdb_tag_i)) begin
                    src1_rdy_d[alloc_slot_s] = 1'b1;
                    src1_val_d[alloc_slot_s] = cdb_data_i;
                end else begin
                    src1_rdy_d[alloc_slot_s] = disp_if.disp_src1_rdy;
                    src1_val_d[alloc_slot_s] = disp_if.disp_src1_val;
                end
                if (!disp_if.disp_src2_rdy && cdb_hit_s && (disp_if.disp_src2_tag == cdb_tag_i)) begin
                    src2_rdy_d[alloc_slot_s] = 1'b1;
                    src2_val_d[alloc_slot_s] = cdb_data_i;
                end else begin
                    src2_rdy_d[alloc_slot_s] = disp_if.disp_src2_rdy;
                    src2_val_d[alloc_slot_s] = disp_if.disp_src2_val;
                end
            end else begin
                valid_d[alloc_slot_s] = valid_d[alloc_slot_s];
            end

            case ({disp_fire_s, iss_fire_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Slot state and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
            occ_q      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                op_q[i]       <= '0;
                tag_q[i]      <= '0;
                src1_tag_q[i] <= '0;
                src2_tag_q[i] <= '0;
                src1_val_q[i] <= '0;
                src2_val_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            src1_rdy_q <= src1_rdy_d;
            src2_rdy_q <= src2_rdy_d;
            occ_q      <= occ_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            src1_tag_q <= src1_tag_d;
            src2_tag_q <= src2_tag_d;
            src1_val_q <= src1_val_d;
            src2_val_q <= src2_val_d;
        end
    end
endmodule
